clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time configuration sequencer for the integer clock divider ClkDiv.
//  Accepts ratio-change requests over a valid/ready handshake and range-checks them.
//  Applies each change glitch-safely: gate the divider enable, wait a guard time,
//  load the new ratio, re-enable, then report lock after one full divided period.
//  Sits in the ref-clock domain next to the divider; drives its enable and ratio inputs.
// PARAMETERS
//  MAX_RATIO     10                      largest legal division ratio
//  RATIO_WIDTH   $clog2(MAX_RATIO)+1     width of ratio buses
//  DEFAULT_RATIO 1                       ratio loaded at reset (0/1 = bypass)
//  GUARD_CYCLES  2                       enable-low cycles before a ratio load (>=1)
// PORTS
//  i_ref_clk    in   1            reference clock, also clocks the divider
//  i_rst        in   1            asynchronous reset, active-high
//  i_sys_en     in   1            global divider run request
//  i_req_valid  in   1            ratio change request valid
//  i_req_ratio  in   RATIO_WIDTH  requested ratio
//  o_req_ready  out  1            request can be accepted this cycle
//  o_req_err    out  1            1-cycle pulse: accepted request was illegal
//  o_clk_en     out  1            to divider i_clk_en
//  o_div_ratio  out  RATIO_WIDTH  to divider i_div_ratio
//  o_busy       out  1            reconfiguration in progress (STOP/LOAD/SETTLE)
//  o_locked     out  1            divider running at stable ratio
// BEHAVIOUR
//  Reset (async): state=IDLE, o_clk_en=0, o_div_ratio=DEFAULT_RATIO, pending=DEFAULT_RATIO,
//   o_req_ready=1, o_req_err=0, o_busy=0, o_locked=0.
//  All outputs registered/Moore; eff = (ratio<2) ? 1 : ratio; counters RATIO_WIDTH bits.
//  Accept = i_req_valid & o_req_ready; legal = i_req_ratio <= MAX_RATIO.
//  o_req_ready = (IDLE) | (RUN & i_sys_en); low in STOP/LOAD/SETTLE.
//  Illegal accept: o_req_err high next cycle for exactly 1 cycle; no state/ratio change.
//  IDLE  : en=0. Legal accept -> o_div_ratio=pending=req next edge (no guard).
//          i_sys_en=1 -> SETTLE (cnt=eff of current ratio). Accept and sys_en same cycle:
//          ratio loaded and SETTLE uses the new eff.
//  RUN   : en=1, locked=1. Legal accept with req!=o_div_ratio -> pending=req, STOP.
//          req==o_div_ratio -> accepted, no effect. i_sys_en=0 -> pending=current, STOP
//          (takes priority; ready is low so no request lost).
//  STOP  : en=0, busy=1, stays exactly GUARD_CYCLES cycles -> LOAD.
//  LOAD  : en=0, busy=1, 1 cycle; edge leaving LOAD writes o_div_ratio=pending;
//          -> SETTLE (cnt=eff(pending)) if i_sys_en else IDLE.
//  SETTLE: en=1, busy=1, locked=0, eff cycles -> RUN. i_sys_en=0 -> STOP (abort),
//          then LOAD/IDLE with unchanged ratio.
//  Latency, legal change accepted at edge T: o_clk_en low at T+1 for GUARD_CYCLES+1
//   cycles; o_div_ratio and o_clk_en change together at T+2+GUARD_CYCLES;
//   o_locked rises eff(new) cycles after that.
//  o_div_ratio never changes while o_clk_en=1 (RUN/SETTLE); divider sees no mid-period update.
//  Reset asserted mid-sequence: immediate return to reset values, pending discarded.
// TESTING
//  1 Reset, sys_en=1 -> en=1 next cycle, ratio=1, locked after 1 cycle; CLK_OUT=ref clk.
//  2 RUN ratio 1, request 4 -> ready low, en low 3 cycles, ratio=4 with en rise,
//    locked 4 cycles later; divided period 40ns at 10ns ref.
//  3 RUN ratio 4, request 11 -> o_req_err 1-cycle pulse, ratio stays 4, en/locked stay 1.
//  4 RUN ratio 4, request 4 -> accepted, no en dip, locked stays 1, err=0.
//  5 Request 6 accepted in IDLE (sys_en=0) -> ratio=6 next edge, en stays 0; then
//    sys_en=1 -> locked after 6 cycles, period 60ns.
//  6 sys_en dropped during SETTLE for ratio 8 -> STOP/LOAD/IDLE, en=0, ratio stays 8;
//    rst pulse mid-STOP -> ratio=DEFAULT_RATIO, all flags 0.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run-time ratio change sequencer for the integer clock divider
// Gates the divider enable, waits a guard time, loads the new ratio, re-enables and reports lock.
module clk_div_ctrl #(
    parameter int MAX_RATIO     = 10,
    parameter int RATIO_WIDTH   = $clog2(MAX_RATIO) + 1,
    parameter int DEFAULT_RATIO = 1,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_sys_en,
    input  logic                   i_req_valid,
    input  logic [RATIO_WIDTH-1:0] i_req_ratio,
    output logic                   o_req_ready,
    output logic                   o_req_err,
    output logic                   o_clk_en,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_busy,
    output logic                   o_locked
);

    localparam int W = RATIO_WIDTH;
    localparam logic [W-1:0] DEF_R = W'(DEFAULT_RATIO);
    localparam logic [W-1:0] GUARD = W'(GUARD_CYCLES);
    localparam logic [W-1:0] MAX_R = W'(MAX_RATIO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STOP,
        S_LOAD,
        S_SETTLE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   ratio_q, ratio_d;
    logic [W-1:0]   pending_q, pending_d;
    logic           err_q, err_d;
    logic           en_q, en_d;
    logic           busy_q, busy_d;
    logic           locked_q, locked_d;
    logic           accept;
    logic           legal;

    // Ratios 0 and 1 both mean bypass, which still takes one cycle per output period.
    function automatic logic [W-1:0] eff(input logic [W-1:0] r);
        return (r < W'(2)) ? W'(1) : r;
    endfunction

    assign o_req_ready = (state_q == S_IDLE) | ((state_q == S_RUN) & i_sys_en);
    assign accept      = i_req_valid & o_req_ready;
    assign legal       = (i_req_ratio <= MAX_R);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        pending_d = pending_q;
        err_d     = accept & ~legal;
        case (state_q)
            S_IDLE: begin
                // Divider is gated, so a new ratio can be written straight through.
                if (accept && legal) begin
                    ratio_d   = i_req_ratio;
                    pending_d = i_req_ratio;
                end
                if (i_sys_en) begin
                    state_d = S_SETTLE;
                    cnt_d   = eff(ratio_d);
                end
            end
            S_RUN: begin
                if (!i_sys_en) begin
                    pending_d = ratio_q;
                    state_d   = S_STOP;
                    cnt_d     = GUARD;
                end else if (accept && legal && (i_req_ratio != ratio_q)) begin
                    pending_d = i_req_ratio;
                    state_d   = S_STOP;
                    cnt_d     = GUARD;
                end
            end
            S_STOP: begin
                if (cnt_q <= W'(1)) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            S_LOAD: begin
                ratio_d = pending_q;
                if (i_sys_en) begin
                    state_d = S_SETTLE;
                    cnt_d   = eff(pending_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (!i_sys_en) begin
                    state_d = S_STOP;
                    cnt_d   = GUARD;
                end else if (cnt_q <= W'(1)) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        en_d     = (state_d == S_RUN) || (state_d == S_SETTLE);
        busy_d   = (state_d == S_STOP) || (state_d == S_LOAD) || (state_d == S_SETTLE);
        locked_d = (state_d == S_RUN);
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ratio_q   <= DEF_R;
            pending_q <= DEF_R;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            locked_q  <= locked_d;
        end
    end

    assign o_req_err   = err_q;
    assign o_clk_en    = en_q;
    assign o_div_ratio = ratio_q;
    assign o_busy      = busy_q;
    assign o_locked    = locked_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl
// Directed sequences, an IDLE request table, and randomized RUN-mode traffic against a timeline model.
module tb_clk_div_ctrl;

    localparam int MAXR = 10;
    localparam int RW   = 5;
    localparam int DEFR = 1;
    localparam int G    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sys_en;
    logic          req_valid;
    logic [RW-1:0] req_ratio;
    logic          ready, err, en, busy, locked;
    logic [RW-1:0] ratio;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .MAX_RATIO(MAXR), .RATIO_WIDTH(RW), .DEFAULT_RATIO(DEFR), .GUARD_CYCLES(G)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst      (rst),
        .i_sys_en   (sys_en),
        .i_req_valid(req_valid),
        .i_req_ratio(req_ratio),
        .o_req_ready(ready),
        .o_req_err  (err),
        .o_clk_en   (en),
        .o_div_ratio(ratio),
        .o_busy     (busy),
        .o_locked   (locked)
    );

    typedef struct {
        int req;
        int exp_ratio;
        int exp_err;
    } idle_vec_t;

    function automatic int eff(input int r);
        return (r < 2) ? 1 : r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e_en, input logic e_busy,
                              input logic e_lock, input int e_ratio, input logic e_err);
        chk({tag, ".en"}, en, e_en);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".locked"}, locked, e_lock);
        chk({tag, ".ratio"}, ratio, e_ratio);
        chk({tag, ".err"}, err, e_err);
    endtask

    idle_vec_t vecs[7];
    longint    t_en;
    int        k, chg_k, m_ratio, m_old, d, e_ratio, r;
    logic      m_err, e_en, e_busy, e_lock, v, acc, got_lock;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{6, 6, 0};
        vecs[1] = '{11, 6, 1};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{10, 10, 0};
        vecs[4] = '{31, 10, 1};
        vecs[5] = '{1, 1, 0};
        vecs[6] = '{6, 6, 0};

        rst = 1'b1; sys_en = 1'b0; req_valid = 1'b0; req_ratio = '0;
        tick(); tick();
        expect_out("reset", 0, 0, 0, DEFR, 0);
        chk("reset.ready", ready, 1);
        rst = 1'b0;
        tick();

        // Bypass start-up: enable next cycle, lock one cycle later.
        sys_en = 1'b1;
        tick();
        expect_out("t1_settle", 1, 1, 0, 1, 0);
        tick();
        expect_out("t1_run", 1, 0, 1, 1, 0);

        // Change 1 -> 4 while running.
        req_valid = 1'b1; req_ratio = 4;
        chk("t2_ready_run", ready, 1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i <= G; i++) begin
            expect_out("t2_gap", 0, 1, 0, 1, 0);
            chk("t2_ready_gap", ready, 0);
            tick();
        end
        t_en = $time;
        for (int i = 0; i < 4; i++) begin
            expect_out("t2_settle", 1, 1, 0, 4, 0);
            tick();
        end
        expect_out("t2_run", 1, 0, 1, 4, 0);
        chk("t2_period_ns", 32'($time - t_en), 40);

        // Illegal ratio while running.
        req_valid = 1'b1; req_ratio = 11;
        tick();
        req_valid = 1'b0;
        expect_out("t3_err", 1, 0, 1, 4, 1);
        tick();
        expect_out("t3_after", 1, 0, 1, 4, 0);

        // Same ratio: accepted, no effect.
        req_valid = 1'b1; req_ratio = 4;
        tick();
        req_valid = 1'b0;
        expect_out("t4_same", 1, 0, 1, 4, 0);
        tick();
        expect_out("t4_after", 1, 0, 1, 4, 0);

        // Drop to IDLE, then exercise direct loads from the table.
        sys_en = 1'b0;
        repeat (G + 2) tick();
        expect_out("t5_idle", 0, 0, 0, 4, 0);
        foreach (vecs[i]) begin
            req_valid = 1'b1; req_ratio = RW'(vecs[i].req);
            chk($sformatf("vec%0d.ready", i), ready, 1);
            tick();
            req_valid = 1'b0;
            expect_out($sformatf("vec%0d", i), 0, 0, 0, vecs[i].exp_ratio, vecs[i].exp_err[0]);
        end
        sys_en = 1'b1;
        tick();
        t_en = $time;
        for (int i = 0; i < 6; i++) begin
            expect_out("t5_settle", 1, 1, 0, 6, 0);
            tick();
        end
        expect_out("t5_run", 1, 0, 1, 6, 0);
        chk("t5_period_ns", 32'($time - t_en), 60);

        // Load and start in the same cycle, then abort during SETTLE.
        sys_en = 1'b0;
        repeat (G + 2) tick();
        expect_out("t6_idle", 0, 0, 0, 6, 0);
        req_valid = 1'b1; req_ratio = 8; sys_en = 1'b1;
        tick();
        req_valid = 1'b0;
        expect_out("t6_settle", 1, 1, 0, 8, 0);
        repeat (3) tick();
        sys_en = 1'b0;
        tick();
        expect_out("t6_abort", 0, 1, 0, 8, 0);
        repeat (G + 1) tick();
        expect_out("t6_idle2", 0, 0, 0, 8, 0);
        sys_en = 1'b1;
        tick();
        sys_en = 1'b0;
        tick();
        expect_out("t6_stop", 0, 1, 0, 8, 0);
        #2 rst = 1'b1;
        #1;
        expect_out("t6_async_rst", 0, 0, 0, DEFR, 0);
        chk("t6_rst_ready", ready, 1);
        tick();
        rst = 1'b0;

        // Randomized RUN-mode traffic against a timeline model.
        sys_en = 1'b1;
        got_lock = 1'b0;
        for (int i = 0; i < 20 && !got_lock; i++) begin
            tick();
            got_lock = locked;
        end
        chk("rand_initial_lock", got_lock, 1);
        k = 0; chg_k = -1000; m_ratio = DEFR; m_old = DEFR; m_err = 1'b0;
        for (int it = 0; it < 300; it++) begin
            d = k - chg_k;
            if (d <= G) begin
                e_en = 0; e_busy = 1; e_lock = 0; e_ratio = m_old;
            end else if (d <= G + eff(m_ratio)) begin
                e_en = 1; e_busy = 1; e_lock = 0; e_ratio = m_ratio;
            end else begin
                e_en = 1; e_busy = 0; e_lock = 1; e_ratio = m_ratio;
            end
            expect_out($sformatf("rand%0d", it), e_en, e_busy, e_lock, e_ratio, m_err);
            chk($sformatf("rand%0d.ready", it), ready, e_lock);
            v = ($urandom % 3) == 0;
            r = int'($urandom_range(0, 15));
            req_valid = v; req_ratio = RW'(r);
            acc = v && e_lock;
            tick();
            k++;
            req_valid = 1'b0;
            m_err = acc && (r > MAXR);
            if (acc && r <= MAXR && r != m_ratio) begin
                m_old = m_ratio; m_ratio = r; chg_k = k;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
